// File: rtl/vx_rr_stream_arbiter.sv
// Round-robin N:1 stream arbiter with a single registered output stage.
// Grant search starts at the priority pointer, which advances past each accepted requester.
module vx_rr_stream_arbiter #(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned DATAW    = 32,
  localparam int unsigned LOG_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [LOG_REQS-1:0]       sel_out,
  input  logic                      ready_out
);

  logic                valid_r;
  logic [DATAW-1:0]    data_r;
  logic [LOG_REQS-1:0] sel_r;
  logic [LOG_REQS-1:0] ptr;
  logic [LOG_REQS-1:0] grant;
  logic [NUM_REQS-1:0] upper_valid;
  logic [DATAW-1:0]    data_sel;
  logic                stage_free;
  logic                accept;

  always_comb begin
    upper_valid = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      upper_valid[i] = valid_in[i] && (i >= 32'(ptr));
    end
  end

  // Requesters at or above ptr win first; otherwise wrap to the lowest valid index.
  // Descending scan so the last hit (lowest index) sticks.
  always_comb begin
    grant = '0;
    for (int unsigned i = NUM_REQS; i > 0; i--) begin
      if ((|upper_valid) ? upper_valid[i-1] : valid_in[i-1]) begin
        grant = LOG_REQS'(i - 1);
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (grant == LOG_REQS'(i)) begin
        data_sel = data_in[i*DATAW +: DATAW];
      end
    end
  end

  assign stage_free = !valid_r || ready_out;
  // reset_n gates the strobe so nothing is offered while reset is held.
  assign accept     = reset_n && stage_free && (|valid_in);

  always_comb begin
    ready_in = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      ready_in[i] = accept && (grant == LOG_REQS'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      sel_r   <= '0;
      ptr     <= '0;
    end else if (accept) begin
      valid_r <= 1'b1;
      data_r  <= data_sel;
      sel_r   <= grant;
      ptr     <= (32'(grant) == NUM_REQS - 1) ? '0 : grant + LOG_REQS'(1);
    end else if (ready_out) begin
      valid_r <= 1'b0;
    end
  end

  assign valid_out = valid_r;
  assign data_out  = data_r;
  assign sel_out   = sel_r;

endmodule
